traffic_timer: RTL and testbench



---
 rtl/traffic_pkg.sv | 22 ++
 rtl/traffic_timer_tick_prescaler.sv | 47 ++++
 rtl/traffic_timer.sv | 86 ++++++++
 tb/tb_traffic_timer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared constants for the traffic-light timer and the light-sequencing FSM it feeds.
// Holds default timing parameters and the 6-bit light-state encodings.
package traffic_pkg;

  localparam int DEF_CLK_PER_SEC = 50_000_000;
  localparam int DEF_TS_SEC      = 5;
  localparam int DEF_TL_SEC      = 25;
  localparam int DEF_CNT_W       = 8;

  // Light encodings: {main R, main Y, main G, side R, side Y, side G}
  typedef enum logic [5:0] {
    LIGHT_MAIN_GREEN  = 6'b001_100,
    LIGHT_MAIN_YELLOW = 6'b010_100,
    LIGHT_SIDE_GREEN  = 6'b100_001,
    LIGHT_SIDE_YELLOW = 6'b100_010
  } light_e;

  function automatic int presc_width(input int clk_per_sec);
    return (clk_per_sec > 1) ? $clog2(clk_per_sec) : 1;
  endfunction

endpackage

// File: rtl/traffic_timer_tick_prescaler.sv
// Divides Clk down to a one-cycle-per-second tick; clear restarts the partial second.
// wrap_o is the combinational next-state of tick so the caller can act on the same edge.
module tick_prescaler
  import traffic_pkg::*;
#(
  parameter int CLK_PER_SEC = DEF_CLK_PER_SEC
) (
  input  logic Clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick,
  output logic wrap_o
);

  localparam int PW = presc_width(CLK_PER_SEC);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_SEC - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q;

  always_comb begin
    presc_d = presc_q;
    wrap_o  = 1'b0;
    if (enable) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        wrap_o  = 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (reset || clear) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= wrap_o;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/traffic_timer.sv
// Interval timer for the traffic-light FSM: counts seconds since ST, raises sticky TS/TL.
// Optional Hold input (freeze while held) is built when TRAFFIC_TIMER_HOLD_EN is defined.
module traffic_timer
  import traffic_pkg::*;
#(
  parameter int CLK_PER_SEC = DEF_CLK_PER_SEC,
  parameter int TS_SEC      = DEF_TS_SEC,
  parameter int TL_SEC      = DEF_TL_SEC,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             ST,
`ifdef TRAFFIC_TIMER_HOLD_EN
  input  logic             Hold,
`endif
  output logic             TS,
  output logic             TL,
  output logic             sec_tick,
  output logic [CNT_W-1:0] elapsed
);

  if (CLK_PER_SEC < 1) begin : g_bad_clk
    $error("traffic_timer: CLK_PER_SEC must be >= 1");
  end
  if (TS_SEC < 1) begin : g_bad_ts
    $error("traffic_timer: TS_SEC must be >= 1");
  end
  if (TS_SEC >= TL_SEC) begin : g_bad_order
    $error("traffic_timer: TS_SEC must be less than TL_SEC");
  end
  if (TL_SEC > (2 ** CNT_W) - 1) begin : g_bad_tl
    $error("traffic_timer: TL_SEC does not fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] EL_MAX  = '1;
  localparam logic [CNT_W-1:0] TS_THR  = CNT_W'(TS_SEC);
  localparam logic [CNT_W-1:0] TL_THR  = CNT_W'(TL_SEC);

  logic             count_en;
  logic             wrap;
  logic [CNT_W-1:0] elapsed_q, elapsed_d;
  logic             ts_q, tl_q;

`ifdef TRAFFIC_TIMER_HOLD_EN
  assign count_en = !Hold;
`else
  assign count_en = 1'b1;
`endif

  tick_prescaler #(
    .CLK_PER_SEC (CLK_PER_SEC)
  ) u_presc (
    .Clk    (Clk),
    .reset  (reset),
    .clear  (ST),
    .enable (count_en),
    .tick   (sec_tick),
    .wrap_o (wrap)
  );

  always_comb begin
    elapsed_d = elapsed_q;
    if (wrap && (elapsed_q != EL_MAX)) begin
      elapsed_d = elapsed_q + 1'b1;
    end
  end

  // elapsed never decreases between restarts, so comparing the next value keeps flags sticky
  always_ff @(posedge Clk) begin
    if (reset || ST) begin
      elapsed_q <= '0;
      ts_q      <= 1'b0;
      tl_q      <= 1'b0;
    end else begin
      elapsed_q <= elapsed_d;
      ts_q      <= (elapsed_d >= TS_THR);
      tl_q      <= (elapsed_d >= TL_THR);
    end
  end

  assign elapsed = elapsed_q;
  assign TS      = ts_q;
  assign TL      = tl_q;

endmodule

// File: tb/tb_traffic_timer.sv
// Self-checking bench for traffic_timer with CLK_PER_SEC=4, TS_SEC=2, TL_SEC=5, CNT_W=4.
// Hold scenarios are exercised only when TRAFFIC_TIMER_HOLD_EN is defined.
module tb_traffic_timer;

  localparam int CPS = 4;
  localparam int TSS = 2;
  localparam int TLS = 5;
  localparam int CW  = 4;
  localparam int SAT = 15;

  logic          Clk = 1'b0;
  logic          reset_r = 1'b1;
  logic          st_r = 1'b0;
  logic          hold_r = 1'b0;
  logic          TS, TL, sec_tick;
  logic [CW-1:0] elapsed;

  int total = 0;
  int bad   = 0;

  // reference: active (counting) edges since last restart, and last-edge tick
  int   cnt = 0;
  logic mtick = 1'b0;

  always #5 Clk = ~Clk;

  traffic_timer #(
    .CLK_PER_SEC (CPS),
    .TS_SEC      (TSS),
    .TL_SEC      (TLS),
    .CNT_W       (CW)
  ) dut (
    .Clk      (Clk),
    .reset    (reset_r),
    .ST       (st_r),
`ifdef TRAFFIC_TIMER_HOLD_EN
    .Hold     (hold_r),
`endif
    .TS       (TS),
    .TL       (TL),
    .sec_tick (sec_tick),
    .elapsed  (elapsed)
  );

  function automatic logic [CW-1:0] m_el();
    return ((cnt / CPS) > SAT) ? CW'(SAT) : CW'(cnt / CPS);
  endfunction

  function automatic logic m_ts();
    return (cnt / CPS) >= TSS;
  endfunction

  function automatic logic m_tl();
    return (cnt / CPS) >= TLS;
  endfunction

  // advance one edge, update reference, then settle before sampling
  task automatic adv();
    @(posedge Clk);
    if (reset_r || st_r) begin
      cnt   = 0;
      mtick = 1'b0;
    end else if (hold_r) begin
      mtick = 1'b0;
    end else begin
      cnt   = cnt + 1;
      mtick = ((cnt % CPS) == 0);
    end
    #1;
  endtask

  task automatic test_reset();
    reset_r = 1'b1; st_r = 1'b0; hold_r = 1'b0;
    repeat (3) begin
      adv();
      total++;
      if ({TS, TL, sec_tick, elapsed} !== {1'b0, 1'b0, 1'b0, CW'(0)}) begin
        bad++;
        $display("FAIL reset_state: got TS=%b TL=%b tick=%b el=%0d, want all zero", TS, TL, sec_tick, elapsed);
      end
    end
    reset_r = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      adv();
      total++;
      if (sec_tick !== (k == 4) || elapsed !== CW'(k / 4)) begin
        bad++;
        $display("FAIL first_tick edge %0d: got tick=%b el=%0d, want tick=%b el=%0d", k, sec_tick, elapsed, (k == 4), k / 4);
      end
    end
  endtask

  task automatic test_pulse_free_run();
    logic [CW+2:0] got, want;
    st_r = 1'b1;
    adv();
    st_r = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      adv();
      got  = {TS, TL, sec_tick, elapsed};
      want = {logic'(k >= 8), logic'(k >= 20), logic'((k % 4) == 0), CW'(k / 4)};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL free_run edge %0d: got TS,TL,tick,el=%b, want %b", k, got, want);
      end
    end
  endtask

  task automatic test_st_held();
    st_r = 1'b1;
    for (int k = 0; k < 30; k++) begin
      adv();
      total++;
      if ({TS, TL, sec_tick, elapsed} !== {1'b0, 1'b0, 1'b0, CW'(0)}) begin
        bad++;
        $display("FAIL st_held cycle %0d: got TS=%b TL=%b tick=%b el=%0d, want all zero", k, TS, TL, sec_tick, elapsed);
      end
    end
    st_r = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      adv();
      total++;
      if (TS !== (k == 8)) begin
        bad++;
        $display("FAIL st_release_ts edge %0d: got TS=%b, want %b", k, TS, (k == 8));
      end
    end
  endtask

  task automatic test_mid_restart();
    repeat (4) adv();
    total++;
    if (elapsed !== CW'(3) || TS !== 1'b1) begin
      bad++;
      $display("FAIL mid_pre: got el=%0d TS=%b, want el=3 TS=1", elapsed, TS);
    end
    repeat (2) adv();
    st_r = 1'b1;
    adv();
    st_r = 1'b0;
    total++;
    if ({TS, TL, sec_tick, elapsed} !== {1'b0, 1'b0, 1'b0, CW'(0)}) begin
      bad++;
      $display("FAIL mid_restart: got TS=%b TL=%b tick=%b el=%0d, want all zero", TS, TL, sec_tick, elapsed);
    end
    for (int k = 1; k <= 8; k++) begin
      adv();
      total++;
      if (TS !== (k >= 8) || elapsed !== CW'(k / 4)) begin
        bad++;
        $display("FAIL mid_rerise edge %0d: got TS=%b el=%0d, want TS=%b el=%0d", k, TS, elapsed, (k >= 8), k / 4);
      end
    end
  endtask

  task automatic test_saturate();
    int ticks;
    ticks = 0;
    st_r = 1'b1;
    adv();
    st_r = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      adv();
      if (k > 60 && sec_tick === 1'b1) ticks++;
      total++;
      if ({TS, TL, sec_tick, elapsed} !== {m_ts(), m_tl(), mtick, m_el()}) begin
        bad++;
        $display("FAIL saturate edge %0d: got TS=%b TL=%b tick=%b el=%0d, want %b %b %b %0d",
                 k, TS, TL, sec_tick, elapsed, m_ts(), m_tl(), mtick, m_el());
      end
    end
    total++;
    if (elapsed !== CW'(SAT) || TL !== 1'b1 || ticks != 10) begin
      bad++;
      $display("FAIL saturate_end: got el=%0d TL=%b late_ticks=%0d, want el=15 TL=1 late_ticks=10", elapsed, TL, ticks);
    end
    reset_r = 1'b1; st_r = 1'b1;
    adv();
    reset_r = 1'b0; st_r = 1'b0;
    total++;
    if ({TS, TL, sec_tick, elapsed} !== {1'b0, 1'b0, 1'b0, CW'(0)}) begin
      bad++;
      $display("FAIL reset_and_st: got TS=%b TL=%b tick=%b el=%0d, want all zero", TS, TL, sec_tick, elapsed);
    end
  endtask

`ifdef TRAFFIC_TIMER_HOLD_EN
  task automatic test_hold();
    st_r = 1'b1;
    adv();
    st_r = 1'b0;
    repeat (6) adv();
    hold_r = 1'b1;
    for (int k = 0; k < 10; k++) begin
      adv();
      total++;
      if (elapsed !== CW'(1) || TS !== 1'b0 || sec_tick !== 1'b0) begin
        bad++;
        $display("FAIL hold_frozen cycle %0d: got el=%0d TS=%b tick=%b, want el=1 TS=0 tick=0", k, elapsed, TS, sec_tick);
      end
    end
    hold_r = 1'b0;
    for (int k = 17; k <= 28; k++) begin
      adv();
      total++;
      if (TS !== ((k - 10) >= 8) || sec_tick !== (((k - 10) % 4) == 0) || elapsed !== CW'((k - 10) / 4)) begin
        bad++;
        $display("FAIL hold_resume edge %0d: got TS=%b tick=%b el=%0d, want %b %b %0d",
                 k, TS, sec_tick, elapsed, ((k - 10) >= 8), (((k - 10) % 4) == 0), (k - 10) / 4);
      end
    end
    hold_r = 1'b1; st_r = 1'b1;
    adv();
    hold_r = 1'b0; st_r = 1'b0;
    total++;
    if ({TS, TL, sec_tick, elapsed} !== {1'b0, 1'b0, 1'b0, CW'(0)}) begin
      bad++;
      $display("FAIL hold_vs_st: got TS=%b TL=%b tick=%b el=%0d, want all zero", TS, TL, sec_tick, elapsed);
    end
  endtask
`endif

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      reset_r = ($urandom % 60) == 0;
      st_r    = ($urandom % 25) == 0;
`ifdef TRAFFIC_TIMER_HOLD_EN
      hold_r  = ($urandom % 5) == 0;
`else
      hold_r  = 1'b0;
`endif
      adv();
      total++;
      if ({TS, TL, sec_tick, elapsed} !== {m_ts(), m_tl(), mtick, m_el()}) begin
        bad++;
        $display("FAIL random cycle %0d: got TS=%b TL=%b tick=%b el=%0d, want %b %b %b %0d",
                 k, TS, TL, sec_tick, elapsed, m_ts(), m_tl(), mtick, m_el());
      end
      if (TL === 1'b1 && TS !== 1'b1) begin
        bad++;
        $display("FAIL tl_implies_ts cycle %0d: got TL=1 TS=%b, want TS=1", k, TS);
      end
    end
    reset_r = 1'b0; st_r = 1'b0; hold_r = 1'b0;
  endtask

  initial begin
    test_reset();
    test_pulse_free_run();
    test_st_held();
    test_mid_restart();
    test_saturate();
`ifdef TRAFFIC_TIMER_HOLD_EN
    test_hold();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
